// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first: {borrow_out, diff} = a - b.
// Operands load in parallel on an accepted start. One bit is processed per clock
// through a full-subtractor built from two half-subtractor stages and a registered
// borrow. The result is returned in parallel with a one-cycle done pulse.
module serial_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             bin_q;
    logic [CntW-1:0]  cnt_q;

    logic accept;
    logic last_bit;
    logic hs1_diff, hs1_borrow;
    logic hs2_diff, hs2_borrow;
    logic bit_diff, bit_borrow;

    // Full subtractor: first half-sub on a0/b0, second on that difference and borrow-in
    always_comb begin
        hs1_diff   = a_sh_q[0] ^ b_sh_q[0];
        hs1_borrow = ~a_sh_q[0] & b_sh_q[0];
        hs2_diff   = hs1_diff ^ bin_q;
        hs2_borrow = ~hs1_diff & bin_q;
        bit_diff   = hs2_diff;
        bit_borrow = hs1_borrow | hs2_borrow;
    end

    // Handshake decode: start is honoured in IDLE and DONE, ignored while running
    always_comb begin
        accept   = start && (state_q != StRun);
        last_bit = (state_q == StRun) && (cnt_q == CntLast);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops
    always_comb begin
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Serial datapath: shift operands right, collect result bits from the MSB end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh_q <= a;
            b_sh_q <= b;
            bin_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (state_q == StRun) begin
            a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
            res_q  <= {bit_diff, res_q[WIDTH-1:1]};
            bin_q  <= bit_borrow;
            if (last_bit) begin
                // Final bit lands at the MSB, so the full result is aligned here
                diff_q   <= {bit_diff, res_q[WIDTH-1:1]};
                borrow_q <= bit_borrow;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
